// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and default clocking.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned DATA_BITS     = 8;
  localparam int unsigned DEF_CLK_FREQ  = 50000000;
  localparam int unsigned DEF_BAUD      = 9600;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

endpackage

// File: rtl/uart_os_tick.sv
// Free-running divider producing a one-clock oversample tick every
// CLK_FREQ/(BAUD*OVERSAMPLE) clocks.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic os_tick
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt     <= '0;
      os_tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt     <= '0;
      os_tick <= 1'b1;
    end else begin
      cnt     <= cnt + CW'(1);
      os_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1
// (adds the PARITY state and drives parity_err).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  logic                 os_tick;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_prev;
  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 brk;

  uart_os_tick #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .os_tick (os_tick)
  );

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic par_err_q;
  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      brk       <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          brk <= 1'b0;
          if (rx_prev && !rx_s) begin
            tick_cnt <= '0;
            state    <= ST_START;
          end
        end

        // Re-check the line mid start bit to reject short glitches.
        ST_START: if (os_tick) begin
          if (tick_cnt == HALF) begin
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= ST_DATA;
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end

        ST_DATA: if (os_tick) begin
          if (tick_cnt == LAST) begin
            tick_cnt <= '0;
            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: if (os_tick) begin
          if (tick_cnt == LAST) begin
            tick_cnt <= '0;
            par_bad  <= rx_s ^ (^shreg);
            state    <= ST_STOP;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
`endif

        // After a low stop bit, wait for the line to return high (break hold).
        ST_STOP: begin
          if (brk) begin
            if (rx_s) begin
              brk   <= 1'b0;
              state <= ST_IDLE;
            end
          end else if (os_tick) begin
            if (tick_cnt == LAST) begin
              tick_cnt <= '0;
              rx_data  <= shreg;
              if (!rx_s) begin
                frame_err <= 1'b1;
                brk       <= 1'b1;
              end else begin
`ifdef UART_RX_PARITY_EN
                if (par_bad) par_err_q <= 1'b1;
                else         rx_valid  <= 1'b1;
`else
                rx_valid <= 1'b1;
`endif
                state <= ST_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
